// File: rtl/round_ctrl_if.sv
// Handshake/config bundle between the round sequencer and its client/downstream datapath.
// The sequencer sits on the slave side; the requester/downstream side uses master.
interface round_ctrl_if #(
  parameter int IDX_W = 3
);
  logic             start;
  logic             cfg_last_vld;
  logic [IDX_W-1:0] cfg_last;
  logic             round_ready;
  logic [IDX_W-1:0] round_idx;
  logic             round_valid;
  logic             round_first;
  logic             round_last;
  logic             busy;
  logic             done;

  modport master (
    output start, cfg_last_vld, cfg_last, round_ready,
    input  round_idx, round_valid, round_first, round_last, busy, done
  );

  modport slave (
    input  start, cfg_last_vld, cfg_last, round_ready,
    output round_idx, round_valid, round_first, round_last, busy, done
  );
endinterface

// File: rtl/round_ctrl.sv
// Round sequencer: steps a round index 0..last_q, one value per valid/ready handshake.
// Optional ROUND_CTRL_ABORT_EN adds an abort input that drops a running sequence.
module round_ctrl #(
  parameter int IDX_W    = 3,
  parameter int DEF_LAST = 7
) (
  input  logic clk,
  input  logic rst,
`ifdef ROUND_CTRL_ABORT_EN
  input  logic abort,
`endif
  round_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] DEF_LAST_V = IDX_W'(DEF_LAST);

  logic [1:0]       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_q;
  logic             abort_req;
  logic             in_run;

`ifdef ROUND_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            last_q  <= bus.cfg_last_vld ? bus.cfg_last : DEF_LAST_V;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // abort outranks the handshake, even on the final round
          if (abort_req) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end else if (bus.round_ready) begin
            if (idx_q == last_q) begin
              idx_q   <= '0;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          idx_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_run = (state_q == RUN);

  always_comb begin
    bus.round_idx   = idx_q;
    bus.round_valid = in_run;
    bus.round_first = in_run && (idx_q == '0);
    bus.round_last  = in_run && (idx_q == last_q);
    bus.busy        = in_run || (state_q == DONE);
    bus.done        = (state_q == DONE);
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: queue-based reference model plus directed literal checks.
module tb_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  int   checks = 0;
  int   errors = 0;

  round_ctrl_if #(.IDX_W(3)) bus ();

  round_ctrl #(.IDX_W(3), .DEF_LAST(7)) dut (
    .clk (clk),
    .rst (rst),
`ifdef ROUND_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a started run is the list of round indices still to be accepted.
  int exp_q[$];
  bit m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_done = 1'b0;
    end else begin
      bit idle;
      bit abort_s;
      int lst;
      idle = (exp_q.size() == 0) && !m_done;
`ifdef ROUND_CTRL_ABORT_EN
      abort_s = abort;
`else
      abort_s = 1'b0;
`endif
      m_done = 1'b0;
      if (exp_q.size() != 0) begin
        if (abort_s) exp_q.delete();
        else if (bus.round_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_done = 1'b1;
        end
      end else if (idle && bus.start) begin
        lst = bus.cfg_last_vld ? int'(bus.cfg_last) : 7;
        for (int i = 0; i <= lst; i++) exp_q.push_back(i);
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = (exp_q.size() != 0);
    check("valid", bus.round_valid, ev);
    check("first", bus.round_first, ev && exp_q[0] == 0);
    check("last",  bus.round_last,  ev && exp_q.size() == 1);
    check("busy",  bus.busy, ev || m_done);
    check("done",  bus.done, m_done);
    if (ev) check("idx", bus.round_idx, exp_q[0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit vld, input int lst);
    bus.start = 1'b1;
    bus.cfg_last_vld = vld;
    bus.cfg_last = 3'(lst);
    step();
    bus.start = 1'b0;
  endtask

  int idx_seq3[7] = '{0, 1, 1, 1, 2, 3, 3};
  bit rdy_pat[7]  = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    bus.start = 1'b0;
    bus.cfg_last_vld = 1'b0;
    bus.cfg_last = '0;
    bus.round_ready = 1'b0;
    #12;
    check("rst_valid", bus.round_valid, 0);
    check("rst_idx",   bus.round_idx, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    step();
    rst = 1'b0;
    step();

    // Default last round, ready held high: idx 0..7, done 9th cycle.
    bus.round_ready = 1'b1;
    do_start(1'b0, 5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) begin
        check("t1_idx", bus.round_idx, k);
        check("t1_first", bus.round_first, k == 0);
        check("t1_last", bus.round_last, k == 7);
      end
      check("t1_done", bus.done, k == 8);
      check("t1_busy", bus.busy, k <= 8);
      step();
    end

    // Single-round run.
    do_start(1'b1, 0);
    @(negedge clk);
    check("t2_first", bus.round_first, 1);
    check("t2_last",  bus.round_last, 1);
    step();
    @(negedge clk);
    check("t2_done",  bus.done, 1);
    check("t2_valid", bus.round_valid, 0);
    step();
    @(negedge clk);
    check("t2_busy",  bus.busy, 0);
    step();

    // Ready toggling with last=3.
    do_start(1'b1, 3);
    for (int k = 0; k < 7; k++) begin
      bus.round_ready = rdy_pat[k];
      @(negedge clk);
      check("t3_idx", bus.round_idx, idx_seq3[k]);
      check("t3_done", bus.done, 0);
      step();
    end
    @(negedge clk);
    check("t3_done_end", bus.done, 1);
    step();
    @(negedge clk);
    check("t3_idle", bus.busy, 0);

    // start and cfg changes during RUN and DONE are ignored.
    bus.round_ready = 1'b1;
    step();
    do_start(1'b1, 2);
    bus.start = 1'b1;
    bus.cfg_last = 3'd6;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) check("t4_idx", bus.round_idx, k);
      check("t4_last", bus.round_last, k == 2);
      check("t4_done", bus.done, k == 3);
      step();
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("t4_no_rerun", bus.busy, 0);
    step();

    // Asynchronous reset mid-run at idx 4.
    do_start(1'b0, 0);
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    check("t5_idx4", bus.round_idx, 4);
    #1 rst = 1'b1;
    #1;
    check("t5_valid", bus.round_valid, 0);
    check("t5_idx",   bus.round_idx, 0);
    check("t5_busy",  bus.busy, 0);
    check("t5_done",  bus.done, 0);
    step();
    step();
    rst = 1'b0;
    do_start(1'b1, 1);
    @(negedge clk);
    check("t5_restart", bus.round_idx, 0);
    check("t5_rvalid",  bus.round_valid, 1);
    step();
    step();
    step();

`ifdef ROUND_CTRL_ABORT_EN
    do_start(1'b0, 0);
    for (int k = 0; k < 5; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("t6_valid", bus.round_valid, 0);
    check("t6_done",  bus.done, 0);
    check("t6_busy",  bus.busy, 0);
    step();
    do_start(1'b1, 2);
    @(negedge clk);
    check("t6_restart", bus.round_idx, 0);
    step();
    step();
    step();
    step();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      bus.start        = ($urandom_range(0, 3) == 0);
      bus.cfg_last_vld = $urandom_range(0, 1) == 1;
      bus.cfg_last     = 3'($urandom_range(0, 7));
      bus.round_ready  = ($urandom_range(0, 99) < 70);
`ifdef ROUND_CTRL_ABORT_EN
      abort            = ($urandom_range(0, 29) == 0);
`endif
      rst              = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    abort = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
- Round sequencer for the encryption datapath. Sits directly upstream of the 3-to-8 stage decoder.
- On a start request it captures the last-round number and steps a 3-bit round index from 0 up to that number.
- Each index value is held until the downstream datapath accepts it with a valid/ready handshake. The decoder turns the index into one-hot stage enables.
- Reports busy, first/last-round flags and a one-cycle done pulse.

Parameters:
- IDX_W, 3, width of round index and cfg_last. The decoder consumes exactly 3 bits; other values are unsupported.
- DEF_LAST, 7, last-round value used when cfg_last_vld is low at start.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  start request; sampled only in IDLE
- cfg_last_vld  in  1  when high with start, use cfg_last; else use DEF_LAST
- cfg_last  in  IDX_W  last round index to execute (0..7)
- round_ready  in  1  downstream accepts the current round index
- round_idx  out  IDX_W  current round index (feeds decoder inp_data)
- round_valid  out  1  round_idx is valid
- round_first  out  1  round_valid and round_idx==0
- round_last  out  1  round_valid and round_idx==last_q
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the final round is accepted

Behaviour:
- Interface decided: one clock (clk); reset rst is asynchronous and active-high. All state is cleared on rst assertion and stays cleared while rst is high.
- Reset values: round_idx=0, round_valid=0, round_first=0, round_last=0, busy=0, done=0, last_q=0, state=IDLE.
- States:
  - IDLE: outputs idle. If start=1, capture last_q from cfg_last when cfg_last_vld=1, else from DEF_LAST. Set round_idx=0 and go to RUN.
  - RUN: round_valid=1. If round_ready=1 (handshake) and round_idx!=last_q, increment round_idx next cycle. If a handshake occurs with round_idx==last_q, go to DONE. With no handshake, hold round_idx and round_valid stable.
  - DONE: round_valid=0, done=1 for exactly this cycle, busy=1. Go to IDLE unconditionally.
- Latency:
  - start sampled at edge N; round_valid=1 with round_idx=0 after edge N.
  - One index per cycle when round_ready is held high.
  - done asserts the cycle after the final handshake.
  - Total run from start to done with ready held high: last_q+2 cycles.
- round_idx never wraps. Increment stops at last_q. last_q=0 gives a single round with round_first=round_last=1.
- start in RUN or DONE is ignored and not queued. A start coincident with DONE is dropped.
- cfg_last and cfg_last_vld are ignored outside the start cycle. A change mid-run has no effect.
- rst asserted mid-run: immediate return to IDLE, all outputs 0, no done pulse.
- round_first and round_last are combinational decodes of registered state; no glitch requirement beyond that.

Optional Feature:
- Macro: ROUND_CTRL_ABORT_EN.
- With the macro defined: extra port abort (in, 1).
  - abort=1 in RUN returns the block to IDLE on the next edge. round_valid=0 and round_idx=0 from that edge; done is not pulsed.
  - abort has priority over a simultaneous handshake, including on the last round.
  - abort in IDLE or DONE has no effect. abort and start together in IDLE: start wins.
- Without the macro: no abort port; RUN exits only via the final handshake or rst.

Test Plan:
- Reset then start=1, cfg_last_vld=0, round_ready=1 held -> round_idx 0,1,...,7 on consecutive cycles. round_first only at idx 0, round_last only at idx 7. done pulses 1 cycle after idx 7; busy high for 9 cycles.
- start with cfg_last_vld=1, cfg_last=0 -> single cycle round_valid=1 with idx 0, first=last=1; done the next cycle.
- cfg_last=3 with round_ready toggling 1,0,0,1,1,0,1 -> idx holds during ready=0, progresses 0,1,2,3 only on handshakes. done exactly once, after the idx-3 handshake.
- start pulsed during RUN and on the DONE cycle; cfg_last changed mid-run -> ignored; no second run; last_q unchanged.
- rst asserted asynchronously mid-cycle at idx 4 -> all outputs 0 immediately. No done pulse. A new start after rst release runs from idx 0.
- ROUND_CTRL_ABORT_EN defined: abort at idx 5 of 7, with round_ready=1 -> IDLE next edge, round_valid=0, no done. A following start runs normally from idx 0.
